bus_arbiter: RTL and testbench

//   Shares the single 32-bit memory bus between two requesters: master 0 (CPU

---
 rtl/bus_arbiter_if.sv | 39 +++
 rtl/bus_arbiter.sv | 121 ++++++++++++
 tb/tb_bus_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two requesters, the shared memory bus and bus_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and the bus.
interface bus_arbiter_if;
    logic        m0Request;
    logic [31:0] m0Address;
    logic [31:0] m0DataOut;
    logic        m0WriteEnable;
    logic [31:0] m0DataIn;
    logic        m0Ack;

    logic        m1Request;
    logic [31:0] m1Address;
    logic [31:0] m1DataOut;
    logic        m1WriteEnable;
    logic [31:0] m1DataIn;
    logic        m1Ack;

    logic [31:0] busAddress;
    logic [31:0] busDataOut;
    logic        busWriteEnable;
    logic [31:0] busDataIn;
    logic        busOwner;

    modport slave (
        input  m0Request, m0Address, m0DataOut, m0WriteEnable,
        input  m1Request, m1Address, m1DataOut, m1WriteEnable,
        input  busDataIn,
        output m0DataIn, m0Ack, m1DataIn, m1Ack,
        output busAddress, busDataOut, busWriteEnable, busOwner
    );

    modport master (
        output m0Request, m0Address, m0DataOut, m0WriteEnable,
        output m1Request, m1Address, m1DataOut, m1WriteEnable,
        output busDataIn,
        input  m0DataIn, m0Ack, m1DataIn, m1Ack,
        input  busAddress, busDataOut, busWriteEnable, busOwner
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter that lets two requesters share one 32-bit memory bus.
// Only one transaction is in flight at a time, and every access takes a fixed READ_LATENCY.
module bus_arbiter #(
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

    state_t      r_state,          w_state_nxt;
    logic [3:0]  r_count,          w_count_nxt;
    logic        r_lastGrant,      w_lastGrant_nxt;
    logic        r_busOwner,       w_busOwner_nxt;
    logic [31:0] r_busAddress,     w_busAddress_nxt;
    logic [31:0] r_busDataOut,     w_busDataOut_nxt;
    logic        r_busWriteEnable, w_busWriteEnable_nxt;
    logic [31:0] r_m0DataIn,       w_m0DataIn_nxt;
    logic        r_m0Ack,          w_m0Ack_nxt;
    logic [31:0] r_m1DataIn,       w_m1DataIn_nxt;
    logic        r_m1Ack,          w_m1Ack_nxt;
    logic        w_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_count          <= '0;
            r_lastGrant      <= 1'b1;
            r_busOwner       <= 1'b0;
            r_busAddress     <= '0;
            r_busDataOut     <= '0;
            r_busWriteEnable <= 1'b0;
            r_m0DataIn       <= '0;
            r_m0Ack          <= 1'b0;
            r_m1DataIn       <= '0;
            r_m1Ack          <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_count          <= w_count_nxt;
            r_lastGrant      <= w_lastGrant_nxt;
            r_busOwner       <= w_busOwner_nxt;
            r_busAddress     <= w_busAddress_nxt;
            r_busDataOut     <= w_busDataOut_nxt;
            r_busWriteEnable <= w_busWriteEnable_nxt;
            r_m0DataIn       <= w_m0DataIn_nxt;
            r_m0Ack          <= w_m0Ack_nxt;
            r_m1DataIn       <= w_m1DataIn_nxt;
            r_m1Ack          <= w_m1Ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt          = r_state;
        w_count_nxt          = r_count;
        w_lastGrant_nxt      = r_lastGrant;
        w_busOwner_nxt       = r_busOwner;
        w_busAddress_nxt     = r_busAddress;
        w_busDataOut_nxt     = r_busDataOut;
        w_busWriteEnable_nxt = r_busWriteEnable;
        w_m0DataIn_nxt       = r_m0DataIn;
        w_m0Ack_nxt          = r_m0Ack;
        w_m1DataIn_nxt       = r_m1DataIn;
        w_m1Ack_nxt          = r_m1Ack;
        w_grant              = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.m0Request || bus.m1Request) begin
                    // On a tie, grant the master that did not win last time.
                    w_grant = (bus.m0Request && bus.m1Request) ? ~r_lastGrant : bus.m1Request;
                    w_lastGrant_nxt      = w_grant;
                    w_busOwner_nxt       = w_grant;
                    w_busAddress_nxt     = w_grant ? bus.m1Address     : bus.m0Address;
                    w_busDataOut_nxt     = w_grant ? bus.m1DataOut     : bus.m0DataOut;
                    w_busWriteEnable_nxt = w_grant ? bus.m1WriteEnable : bus.m0WriteEnable;
                    w_count_nxt          = LAT_M1;
                    w_state_nxt          = ACCESS;
                end
            end
            ACCESS: begin
                w_busWriteEnable_nxt = 1'b0;
                if (r_count != 4'd0) begin
                    w_count_nxt = r_count - 4'd1;
                end else begin
                    if (r_busOwner) begin
                        w_m1DataIn_nxt = bus.busDataIn;
                        w_m1Ack_nxt    = 1'b1;
                    end else begin
                        w_m0DataIn_nxt = bus.busDataIn;
                        w_m0Ack_nxt    = 1'b1;
                    end
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_m0Ack_nxt = 1'b0;
                w_m1Ack_nxt = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.busAddress     = r_busAddress;
    assign bus.busDataOut     = r_busDataOut;
    assign bus.busWriteEnable = r_busWriteEnable;
    assign bus.busOwner       = r_busOwner;
    assign bus.m0DataIn       = r_m0DataIn;
    assign bus.m0Ack          = r_m0Ack;
    assign bus.m1DataIn       = r_m1DataIn;
    assign bus.m1Ack          = r_m1Ack;
endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter that runs READ_LATENCY=2 and READ_LATENCY=1 builds side by side.
// A cycle-counting transaction model predicts grants, bus outputs and acks for each build.
module tb_bus_arbiter;
    localparam int M_QUIET  = 0;
    localparam int M_TIE    = 1;
    localparam int M_SINGLE = 2;
    localparam int M_M1RD   = 3;
    localparam int M_RAND   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_arbiter_if bif2 ();
    bus_arbiter_if bif1 ();

    bus_arbiter #(.READ_LATENCY(2)) u_dut_rl2 (.clk(clk), .reset(reset), .bus(bif2.slave));
    bus_arbiter #(.READ_LATENCY(1)) u_dut_rl1 (.clk(clk), .reset(reset), .bus(bif1.slave));

    // Stimulus per build [d] and per master [m]. Build 0 is READ_LATENCY=2, build 1 is READ_LATENCY=1.
    logic        rq  [2][2];
    logic [31:0] adr [2][2];
    logic [31:0] wdt [2][2];
    logic        wen [2][2];
    int          gap [2][2];
    logic [31:0] bdin[2];

    logic [31:0] o_addr[2], o_dout[2], o_din0[2], o_din1[2];
    logic        o_we[2], o_own[2], o_ack0[2], o_ack1[2];

    assign bif2.m0Request = rq[0][0];  assign bif2.m1Request = rq[0][1];
    assign bif2.m0Address = adr[0][0]; assign bif2.m1Address = adr[0][1];
    assign bif2.m0DataOut = wdt[0][0]; assign bif2.m1DataOut = wdt[0][1];
    assign bif2.m0WriteEnable = wen[0][0]; assign bif2.m1WriteEnable = wen[0][1];
    assign bif2.busDataIn = bdin[0];
    assign bif1.m0Request = rq[1][0];  assign bif1.m1Request = rq[1][1];
    assign bif1.m0Address = adr[1][0]; assign bif1.m1Address = adr[1][1];
    assign bif1.m0DataOut = wdt[1][0]; assign bif1.m1DataOut = wdt[1][1];
    assign bif1.m0WriteEnable = wen[1][0]; assign bif1.m1WriteEnable = wen[1][1];
    assign bif1.busDataIn = bdin[1];

    assign o_addr[0] = bif2.busAddress;  assign o_addr[1] = bif1.busAddress;
    assign o_dout[0] = bif2.busDataOut;  assign o_dout[1] = bif1.busDataOut;
    assign o_we[0]   = bif2.busWriteEnable; assign o_we[1] = bif1.busWriteEnable;
    assign o_own[0]  = bif2.busOwner;    assign o_own[1]  = bif1.busOwner;
    assign o_din0[0] = bif2.m0DataIn;    assign o_din0[1] = bif1.m0DataIn;
    assign o_din1[0] = bif2.m1DataIn;    assign o_din1[1] = bif1.m1DataIn;
    assign o_ack0[0] = bif2.m0Ack;       assign o_ack0[1] = bif1.m0Ack;
    assign o_ack1[0] = bif2.m1Ack;       assign o_ack1[1] = bif1.m1Ack;

    // Model state: a grant is allowed once the edge index reaches e_free.
    // The ack lands exactly rl edges after the grant edge.
    int          e_start[2], e_free[2];
    logic        e_last[2], e_own[2], e_we[2], e_ack0[2], e_ack1[2];
    logic [31:0] e_addr[2], e_dout[2], e_din0[2], e_din1[2];

    int n = 0;
    int n_total = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic stim(input int d, input int m, input int mode);
        bit en;
        logic ack;
        en  = (mode == M_TIE) || (mode == M_SINGLE && m == 0) || (mode == M_M1RD && m == 1) ||
              (mode == M_RAND && $urandom_range(0, 2) != 0);
        ack = (m == 1) ? o_ack1[d] : o_ack0[d];
        if (rq[d][m]) begin
            if (ack === 1'b1) begin
                rq[d][m]  = 1'b0;
                gap[d][m] = (mode == M_RAND) ? int'($urandom_range(0, 3)) : 0;
            end else if (mode == M_RAND && $urandom_range(0, 3) == 0) begin
                adr[d][m] = $urandom;
                wdt[d][m] = $urandom;
                wen[d][m] = 1'($urandom_range(0, 1));
            end
        end else if (gap[d][m] > 0) begin
            gap[d][m]--;
        end else if (en) begin
            rq[d][m]  = 1'b1;
            adr[d][m] = $urandom;
            wdt[d][m] = $urandom;
            wen[d][m] = (mode == M_M1RD) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic model_edge(input int d, input bit rst);
        int rl;
        logic g;
        rl = (d == 0) ? 2 : 1;
        if (rst) begin
            e_last[d] = 1'b1; e_own[d] = 1'b0; e_we[d] = 1'b0;
            e_ack0[d] = 1'b0; e_ack1[d] = 1'b0;
            e_addr[d] = '0; e_dout[d] = '0; e_din0[d] = '0; e_din1[d] = '0;
            e_start[d] = -1000;
            e_free[d]  = n + 1;
        end else begin
            e_ack0[d] = 1'b0; e_ack1[d] = 1'b0; e_we[d] = 1'b0;
            if (n == e_start[d] + rl) begin
                if (e_own[d]) begin e_din1[d] = bdin[d]; e_ack1[d] = 1'b1; end
                else          begin e_din0[d] = bdin[d]; e_ack0[d] = 1'b1; end
            end
            if (n >= e_free[d] && (rq[d][0] || rq[d][1])) begin
                g = (rq[d][0] && rq[d][1]) ? ~e_last[d] : rq[d][1];
                e_last[d]  = g;
                e_own[d]   = g;
                e_addr[d]  = adr[d][g];
                e_dout[d]  = wdt[d][g];
                e_we[d]    = wen[d][g];
                e_start[d] = n;
                e_free[d]  = n + rl + 2;
            end
        end
    endtask

    task automatic cycle(input int mode, input bit rst);
        string p;
        reset = rst;
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) stim(d, m, mode);
            bdin[d] = $urandom;
        end
        for (int d = 0; d < 2; d++) model_edge(d, rst);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            p = $sformatf("rl%0d_c%0d", (d == 0) ? 2 : 1, n);
            chk({p, "_busAddress"},     o_addr[d],       e_addr[d]);
            chk({p, "_busDataOut"},     o_dout[d],       e_dout[d]);
            chk({p, "_busWriteEnable"}, 32'(o_we[d]),    32'(e_we[d]));
            chk({p, "_busOwner"},       32'(o_own[d]),   32'(e_own[d]));
            chk({p, "_m0Ack"},          32'(o_ack0[d]),  32'(e_ack0[d]));
            chk({p, "_m1Ack"},          32'(o_ack1[d]),  32'(e_ack1[d]));
            chk({p, "_m0DataIn"},       o_din0[d],       e_din0[d]);
            chk({p, "_m1DataIn"},       o_din1[d],       e_din1[d]);
            chk({p, "_ackExclusive"},   32'(o_ack0[d] & o_ack1[d]), 32'd0);
        end
        n++;
        @(negedge clk);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            bdin[d] = '0;
            for (int m = 0; m < 2; m++) begin
                rq[d][m] = 1'b0; adr[d][m] = '0; wdt[d][m] = '0; wen[d][m] = 1'b0; gap[d][m] = 0;
            end
        end
        reset = 1'b1;
        @(negedge clk);

        repeat (3)  cycle(M_QUIET, 1'b1);
        repeat (30) cycle(M_TIE, 1'b0);
        repeat (10) cycle(M_QUIET, 1'b0);
        cycle(M_QUIET, 1'b1);
        repeat (30) cycle(M_SINGLE, 1'b0);
        repeat (10) cycle(M_QUIET, 1'b0);
        // An m1 read is granted at E0, and reset lands on E1. The following tie must then go to m0.
        cycle(M_M1RD, 1'b0);
        cycle(M_M1RD, 1'b1);
        repeat (20) cycle(M_TIE, 1'b0);
        for (int i = 0; i < 1500; i++) cycle(M_RAND, ($urandom_range(0, 199) == 0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
